serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 113 +++++++++++
 tb/tb_serial_add_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: one shared fulladder walks the operands LSB first,
// one bit per clock, with start/ready on the input side and valid/ready on the result.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             start_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             result_valid,
    input  logic             result_ready
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result_sh;
    logic            carry;
    logic [CW-1:0]   count;
    logic            fa_s;
    logic            fa_cout;
    logic            last_step;

    fulladder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)                       state_next = RUN;
            RUN:     if (last_step)                   state_next = DONE;
            DONE:    if (result_ready)                state_next = IDLE;
            default:                                  state_next = IDLE;
        endcase
    end

    always_comb begin
        start_ready  = (state == IDLE);
        result_valid = (state == DONE);
    end

    // Subtraction is a + ~b + 1: invert b at capture and seed the carry with sub.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            result_sh <= '0;
            carry     <= 1'b0;
            count     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sh      <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh      <= {1'b0, b_sh[WIDTH-1:1]};
                    result_sh <= {fa_s, result_sh[WIDTH-1:1]};
                    carry     <= fa_cout;
                    count     <= count + 1'b1;
                    if (last_step) begin
                        result    <= {fa_s, result_sh[WIDTH-1:1]};
                        carry_out <= fa_cout;
                        overflow  <= carry ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: the driver pushes model results, the monitor
// pops them when result_valid rises and checks latency, values and hold behaviour.

module tb_serial_add_ctrl;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             start_ready;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             result_valid;
    logic             result_ready;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             co;
        logic             ov;
        int               acc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;
    logic consumed = 1'b0;
    bit   rand_ready = 1'b0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_ready  (start_ready),
        .sub          (sub),
        .a            (a),
        .b            (b),
        .result       (result),
        .carry_out    (carry_out),
        .overflow     (overflow),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ready) result_ready = ($urandom_range(0, 3) != 0);
    end

    // Reference: plain unsigned arithmetic for result/carry, signed range check for overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic ms, input int acc);
        exp_t e;
        logic [WIDTH:0] wide;
        longint sa, sb, st;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (ms) begin
            e.r  = ma - mb;
            e.co = (ma >= mb);
            st   = sa - sb;
        end else begin
            wide = {1'b0, ma} + {1'b0, mb};
            e.r  = wide[WIDTH-1:0];
            e.co = wide[WIDTH];
            st   = sa + sb;
        end
        e.ov  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
        e.acc = acc;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                                 input logic ts);
        int n = 0;
        @(posedge clk); #1;
        while (!start_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!start_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL start_ready timeout: got 0, expected 1");
            return;
        end
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        sub   = ts;
        q.push_back(model(ta, tb_v, ts, cyc + 1));
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sub   = 1'($urandom);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((q.size() != 0 || result_valid || consumed) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drain queue empty", 64'(q.size()), 64'd0);
        checkOutput("drain valid low", 64'(result_valid), 64'd0);
    endtask

    // Monitor: pop on rising valid, then check every DONE cycle for stable, expected fields.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            consumed   = 1'b0;
        end else begin
            if (consumed) begin
                checkOutput("start_ready after consume", 64'(start_ready), 64'd1);
                checkOutput("valid cleared after consume", 64'(result_valid), 64'd0);
                consumed = 1'b0;
            end
            if (result_valid && !prev_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected result: got valid=1, expected no result");
                    cur = '{r: '0, co: 1'b0, ov: 1'b0, acc: cyc - WIDTH};
                end else begin
                    cur = q.pop_front();
                    checkOutput("latency", 64'(cyc - cur.acc), 64'(WIDTH));
                end
            end
            if (result_valid) begin
                checkOutput("result", 64'(result), 64'(cur.r));
                checkOutput("carry_out", 64'(carry_out), 64'(cur.co));
                checkOutput("overflow", 64'(overflow), 64'(cur.ov));
                checkOutput("start_ready in DONE", 64'(start_ready), 64'd0);
                if (result_ready) consumed = 1'b1;
            end
            prev_valid = result_valid;
        end
    end

    initial begin
        int n;
        reset        = 1'b1;
        start        = 1'b0;
        sub          = 1'b0;
        a            = '0;
        b            = '0;
        result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset start_ready", 64'(start_ready), 64'd1);
        checkOutput("reset result_valid", 64'(result_valid), 64'd0);
        checkOutput("reset result", 64'(result), 64'd0);
        checkOutput("reset carry_out", 64'(carry_out), 64'd0);
        checkOutput("reset overflow", 64'(overflow), 64'd0);

        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1);
        waitIdle();

        // Backpressure: hold the result while a stray start is offered and must be ignored.
        result_ready = 1'b0;
        applyStimulus(32'h0000_1234, 32'h0000_4321, 1'b0);
        n = 0;
        while (!result_valid && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        sub   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 result_ready = 1'b1;
        applyStimulus(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
        waitIdle();

        // Abort mid-run with reset; the aborted result must never appear.
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abort result_valid", 64'(result_valid), 64'd0);
        checkOutput("abort result", 64'(result), 64'd0);
        checkOutput("abort start_ready", 64'(start_ready), 64'd1);
        applyStimulus(32'h0000_0010, 32'h0000_0020, 1'b0);
        waitIdle();

        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) ra = 32'h8000_0000;
            if (i % 7 == 0) rb = 32'h7FFF_FFFF;
            applyStimulus(ra, rb, 1'($urandom));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 result_ready = 1'b1;
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
